uart_cmd_assembler: RTL and testbench
=====================================

UART_CMD_ASSEMBLER -- requirements
Module: uart_cmd_assembler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1000000, is the inter-byte timeout in clk cycles; legal range is 2..2^24-1.
REQ-002 Port: clk  input  1  sole clock; all state is updated on its rising edge.
REQ-003 Port: resetn  input  1  asynchronous, active-low reset.
REQ-004 Port: rx_data  input  8  received UART byte from the receiver stage.
REQ-005 Port: rx_valid  input  1  one-cycle strobe; rx_data is valid in the same cycle.
REQ-006 Port: cmd_frame  output  48  assembled SD command frame, MSB is sent first.
REQ-007 Port: cmd_valid  output  1  cmd_frame is valid and held stable.
REQ-008 Port: cmd_ready  input  1  the downstream SD command engine accepts cmd_frame.
REQ-009 Port: busy  output  1  high in any state other than IDLE.
REQ-010 Port: err_timeout  output  1  one-cycle pulse when a partial command is abandoned.
REQ-011 Port: err_index  output  1  one-cycle pulse when a first byte is rejected.
REQ-012 Port: err_overrun  output  1  one-cycle pulse when a byte is dropped during PRESENT.

Function
REQ-013 The state machine SHALL have three states: IDLE, COLLECT and PRESENT.
REQ-014 In IDLE, on rx_valid with rx_data[7:6]==2'b01, the block SHALL store the byte as the index byte, clear the byte count to 1, clear the timeout counter, and go to COLLECT.
REQ-015 In IDLE, on rx_valid with rx_data[7:6]!=2'b01, the block SHALL discard the byte, pulse err_index on the next cycle, and stay in IDLE.
REQ-016 In COLLECT, each rx_valid SHALL shift rx_data into the 32-bit argument register MSB-first, increment the byte count, and clear the timeout counter.
REQ-017 When the 5th byte (byte count reaches 5) is accepted, the block SHALL go to PRESENT and assert cmd_valid in the next cycle (1-cycle latency).
REQ-018 The frame SHALL be {index[7:0], arg[31:0], crc7[6:0], 1'b1}.
REQ-019 The CRC SHALL be CRC7 with polynomial x^7+x^3+1, initial value 0, computed over the 40 bits index||arg MSB-first.
REQ-020 The CRC SHALL be updated byte-wise in the same cycle each byte is accepted, so no extra cycles are spent.
REQ-021 In COLLECT with no rx_valid, the timeout counter SHALL increment each cycle.
REQ-022 When the timeout counter reaches TIMEOUT_CYCLES-1, the block SHALL discard the partial command, pulse err_timeout, and go to IDLE.
REQ-023 If rx_valid coincides with the timeout terminal count, the byte SHALL be accepted and the timeout SHALL NOT fire.
REQ-024 In PRESENT, cmd_frame and cmd_valid SHALL hold until cmd_valid && cmd_ready is sampled high; then cmd_valid SHALL deassert the next cycle and the state SHALL go to IDLE.
REQ-025 In PRESENT, any rx_valid byte SHALL be dropped and err_overrun pulsed.
REQ-026 If rx_valid coincides with the accepting handshake, that byte SHALL also be dropped and err_overrun pulsed; it SHALL NOT start a new command.
REQ-027 cmd_ready SHALL be ignored outside PRESENT.
REQ-028 The timeout counter SHALL be 24 bits wide and SHALL NOT run in IDLE or PRESENT.
REQ-029 Error pulses SHALL be registered, exactly one cycle wide, and mutually exclusive per event.

Reset
REQ-030 While resetn is low: state=IDLE, cmd_frame=48'h0, cmd_valid=0, busy=0, all error outputs=0, byte count=0, CRC=0, timeout counter=0.
REQ-031 Assertion of resetn mid-command or mid-PRESENT SHALL abandon the command immediately with no error pulse.
REQ-032 After resetn deasserts, the first rx_valid SHALL be processed normally.

Verification
REQ-033 Bytes 40,00,00,00,00 with cmd_ready=1 -> cmd_frame=48'h400000000095 and cmd_valid high for exactly 1 cycle, asserted the cycle after the 5th byte.
REQ-034 Bytes 48,00,00,01,AA with cmd_ready low for 10 cycles -> cmd_frame=48'h48000001AA87 held stable for those 10 cycles, then cleared after the handshake.
REQ-035 First byte 0xC0, then 40,00,00,00,00 -> err_index pulse for the 0xC0 byte, followed by a correct CMD0 frame.
REQ-036 TIMEOUT_CYCLES=16, bytes 40,00 then idle -> err_timeout pulse 16 cycles after the last byte, then busy=0; a following full CMD0 still succeeds.
REQ-037 A byte sent during PRESENT, and a byte sent in the handshake cycle -> one err_overrun pulse each, with cmd_frame unchanged.
REQ-038 resetn pulsed low after 3 bytes -> all outputs return to reset values; a following 5-byte command assembles correctly.

Source files
------------

// File: rtl/uart_cmd_assembler_if.sv
// uart_cmd_assembler_if: byte input, SD command frame handshake and status between receiver and command engine
interface uart_cmd_assembler_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [47:0] cmd_frame;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        busy;
    logic        err_timeout;
    logic        err_index;
    logic        err_overrun;

    modport slave (
        input  rx_data, rx_valid, cmd_ready,
        output cmd_frame, cmd_valid, busy, err_timeout, err_index, err_overrun
    );

    modport master (
        output rx_data, rx_valid, cmd_ready,
        input  cmd_frame, cmd_valid, busy, err_timeout, err_index, err_overrun
    );
endinterface

// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler: packs five UART bytes (index + 32-bit arg) into a 48-bit SD command with CRC7
module uart_cmd_assembler #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic               clk,
    input logic               resetn,
    uart_cmd_assembler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, PRESENT} state_t;

    state_t      state;
    logic [7:0]  idx;
    logic [23:0] arg;
    logic [6:0]  crc;
    logic [2:0]  cnt;
    logic [23:0] tmo;
    logic [6:0]  crc_nxt;

    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

    // CRC7 (x^7+x^3+1) advanced over a whole byte, MSB first
    function automatic logic [6:0] crc7_byte(input logic [6:0] c, input logic [7:0] b);
        logic [6:0] r;
        r = c;
        for (int i = 7; i >= 0; i--)
            r = {r[5:0], 1'b0} ^ ((r[6] ^ b[i]) ? 7'h09 : 7'h00);
        return r;
    endfunction

    assign crc_nxt  = crc7_byte(state == IDLE ? 7'd0 : crc, bus.rx_data);
    assign bus.busy = state != IDLE;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            idx             <= '0;
            arg             <= '0;
            crc             <= '0;
            cnt             <= '0;
            tmo             <= '0;
            bus.cmd_frame   <= '0;
            bus.cmd_valid   <= 1'b0;
            bus.err_timeout <= 1'b0;
            bus.err_index   <= 1'b0;
            bus.err_overrun <= 1'b0;
        end else begin
            bus.err_timeout <= 1'b0;
            bus.err_index   <= 1'b0;
            bus.err_overrun <= 1'b0;
            case (state)
                IDLE: if (bus.rx_valid) begin
                    if (bus.rx_data[7:6] == 2'b01) begin
                        idx   <= bus.rx_data;
                        crc   <= crc_nxt;
                        cnt   <= 3'd1;
                        tmo   <= '0;
                        state <= COLLECT;
                    end else begin
                        bus.err_index <= 1'b1;
                    end
                end
                COLLECT: if (bus.rx_valid) begin
                    // a byte on the terminal count wins over the timeout
                    arg <= {arg[15:0], bus.rx_data};
                    crc <= crc_nxt;
                    cnt <= cnt + 3'd1;
                    tmo <= '0;
                    if (cnt == 3'd4) begin
                        bus.cmd_frame <= {idx, arg, bus.rx_data, crc_nxt, 1'b1};
                        bus.cmd_valid <= 1'b1;
                        state         <= PRESENT;
                    end
                end else if (tmo == TMO_LAST) begin
                    bus.err_timeout <= 1'b1;
                    cnt             <= '0;
                    crc             <= '0;
                    tmo             <= '0;
                    state           <= IDLE;
                end else begin
                    tmo <= tmo + 24'd1;
                end
                PRESENT: begin
                    if (bus.rx_valid)
                        bus.err_overrun <= 1'b1;
                    if (bus.cmd_ready) begin
                        bus.cmd_frame <= '0;
                        bus.cmd_valid <= 1'b0;
                        cnt           <= '0;
                        crc           <= '0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_assembler.sv
// tb_uart_cmd_assembler: directed checks of frame assembly, CRC, handshake, timeout, errors and reset
module tb_uart_cmd_assembler;
    localparam logic [47:0] F_CMD0  = 48'h400000000095;
    localparam logic [47:0] F_CMD8  = 48'h48000001AA87;
    localparam logic [47:0] F_CMD55 = 48'h770000000065;
    localparam logic [47:0] F_CMD41 = 48'h694000000077;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   n_valid = 0, n_tmo = 0, n_idx = 0, n_ovr = 0, n_multi = 0;

    uart_cmd_assembler_if bus();

    uart_cmd_assembler #(.TIMEOUT_CYCLES(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_valid = n_valid + int'(bus.cmd_valid);
        n_tmo   = n_tmo + int'(bus.err_timeout);
        n_idx   = n_idx + int'(bus.err_index);
        n_ovr   = n_ovr + int'(bus.err_overrun);
        if (int'(bus.err_timeout) + int'(bus.err_index) + int'(bus.err_overrun) > 1)
            n_multi = n_multi + 1;
    end

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [39:0] bytes);
        for (int i = 4; i >= 0; i--)
            send(bytes[i*8 +: 8]);
    endtask

    // {cmd_valid, busy, err_timeout, err_index, err_overrun}
    function automatic logic [4:0] flags();
        return {bus.cmd_valid, bus.busy, bus.err_timeout, bus.err_index, bus.err_overrun};
    endfunction

    initial begin
        int v0, unstable, t0, e0;
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.cmd_ready = 1'b0;
        tick();
        tick();
        chk("reset_frame", bus.cmd_frame, 48'h0);
        chk("reset_flags", 48'(flags()), 48'h0);
        resetn = 1'b1;
        tick();

        // CMD0 with cmd_ready already high: valid for exactly one cycle
        bus.cmd_ready = 1'b1;
        v0 = n_valid;
        send_cmd(40'h4000000000);
        chk("cmd0_frame", bus.cmd_frame, F_CMD0);
        chk("cmd0_flags", 48'(flags()), 48'h18);
        tick();
        chk("cmd0_after", 48'(flags()), 48'h0);
        chk("cmd0_cleared", bus.cmd_frame, 48'h0);
        tick();
        chk("cmd0_valid_cycles", 48'(n_valid - v0), 48'd1);

        // CMD8 held while cmd_ready low for 10 cycles
        bus.cmd_ready = 1'b0;
        send_cmd(40'h48000001AA);
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.cmd_frame !== F_CMD8 || bus.cmd_valid !== 1'b1) unstable++;
            tick();
        end
        chk("cmd8_frame", bus.cmd_frame, F_CMD8);
        chk("cmd8_unstable", 48'(unstable), 48'd0);
        bus.cmd_ready = 1'b1;
        tick();
        bus.cmd_ready = 1'b0;
        chk("cmd8_released", 48'(flags()), 48'h0);
        chk("cmd8_cleared", bus.cmd_frame, 48'h0);

        // bad index byte then a good CMD0
        send(8'hC0);
        chk("idx_pulse", 48'(flags()), 48'h02);
        tick();
        chk("idx_pulse_end", 48'(flags()), 48'h0);
        send_cmd(40'h4000000000);
        chk("idx_cmd0_frame", bus.cmd_frame, F_CMD0);
        bus.cmd_ready = 1'b1;
        tick();
        bus.cmd_ready = 1'b0;

        // timeout fires 16 cycles after the last byte
        send(8'h40);
        send(8'h00);
        unstable = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.err_timeout !== 1'b0 || bus.busy !== 1'b1) unstable++;
        end
        chk("tmo_early", 48'(unstable), 48'd0);
        tick();
        chk("tmo_pulse", 48'(flags()), 48'h04);
        tick();
        chk("tmo_pulse_end", 48'(flags()), 48'h0);
        send_cmd(40'h4000000000);
        chk("tmo_cmd0_frame", bus.cmd_frame, F_CMD0);
        bus.cmd_ready = 1'b1;
        tick();
        bus.cmd_ready = 1'b0;

        // byte arriving exactly on the terminal count is accepted
        t0 = n_tmo;
        send(8'h77);
        for (int i = 0; i < 15; i++) tick();
        send(8'h00);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        chk("tmo_edge_frame", bus.cmd_frame, F_CMD55);
        chk("tmo_edge_no_err", 48'(n_tmo - t0), 48'd0);

        // overrun during PRESENT and in the handshake cycle
        bus.cmd_ready = 1'b1;
        tick();
        bus.cmd_ready = 1'b0;
        e0 = n_ovr;
        send_cmd(40'h6940000000);
        send(8'h40);
        chk("ovr_pulse", 48'(flags()), 48'h19);
        chk("ovr_frame", bus.cmd_frame, F_CMD41);
        tick();
        chk("ovr_pulse_end", 48'(flags()), 48'h18);
        bus.cmd_ready = 1'b1;
        send(8'h40);
        bus.cmd_ready = 1'b0;
        chk("ovr_hs_pulse", 48'(flags()), 48'h01);
        tick();
        chk("ovr_hs_idle", 48'(flags()), 48'h0);
        chk("ovr_count", 48'(n_ovr - e0), 48'd2);

        // reset mid-command and mid-PRESENT
        e0 = n_tmo + n_idx + n_ovr;
        send(8'h48);
        send(8'h00);
        send(8'h00);
        resetn = 1'b0;
        #1;
        chk("rst_mid_flags", 48'(flags()), 48'h0);
        tick();
        resetn = 1'b1;
        tick();
        send_cmd(40'h48000001AA);
        chk("rst_cmd8_frame", bus.cmd_frame, F_CMD8);
        resetn = 1'b0;
        #1;
        chk("rst_present_frame", bus.cmd_frame, 48'h0);
        chk("rst_present_flags", 48'(flags()), 48'h0);
        tick();
        resetn = 1'b1;
        send_cmd(40'h4000000000);
        chk("rst_after_frame", bus.cmd_frame, F_CMD0);
        bus.cmd_ready = 1'b1;
        tick();
        bus.cmd_ready = 1'b0;
        tick();
        chk("rst_no_errs", 48'(n_tmo + n_idx + n_ovr - e0), 48'd0);
        chk("err_exclusive", 48'(n_multi), 48'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
